// File: rtl/bitty_pkg.sv
// Shared fetch-side definitions: default widths, reset PC and the fetch FSM encoding.
package bitty_pkg;

   localparam int unsigned DEF_ADDR_W   = 8;
   localparam int unsigned DEF_INSTR_W  = 16;
   localparam int unsigned DEF_RESET_PC = 0;
   localparam int unsigned DEF_TIMEOUT  = 16;
   localparam int unsigned RETIRE_W     = 16;
   localparam int unsigned WCNT_W       = 8;

   // Encoding is exposed to debug, so values are pinned.
   typedef enum logic [1:0] {
      REQ  = 2'd0,
      WAIT = 2'd1,
      HOLD = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// Program counter owner and instruction fetcher (REQ -> WAIT -> HOLD).
// Optional read-data timeout enabled with `define FETCH_TIMEOUT_EN.
module fetch_unit
   import bitty_pkg::*;
#(
   parameter int unsigned ADDR_W   = DEF_ADDR_W,
   parameter int unsigned INSTR_W  = DEF_INSTR_W,
   parameter int unsigned RESET_PC = DEF_RESET_PC,
   parameter int unsigned TIMEOUT  = DEF_TIMEOUT
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [ADDR_W-1:0]   next_pc,
   input  logic                instr_done,
   output logic                mem_req,
   output logic [ADDR_W-1:0]   mem_addr,
   input  logic                mem_gnt,
   input  logic                mem_rvalid,
   input  logic [INSTR_W-1:0]  mem_rdata,
   output logic [ADDR_W-1:0]   pc,
   output logic [INSTR_W-1:0]  instr,
   output logic                instr_valid,
   output logic [RETIRE_W-1:0] retire_count,
   output logic                fetch_err
);

   fetch_state_e        state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [INSTR_W-1:0]  instr_q, instr_d;
   logic                valid_q, valid_d;
   logic [RETIRE_W-1:0] cnt_q, cnt_d;
`ifdef FETCH_TIMEOUT_EN
   logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
   logic                err_q, err_d;
`endif

   // State and datapath registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= REQ;
         pc_q    <= ADDR_W'(RESET_PC);
         instr_q <= '0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
`ifdef FETCH_TIMEOUT_EN
         wcnt_q  <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
`ifdef FETCH_TIMEOUT_EN
         wcnt_q  <= wcnt_d;
         err_q   <= err_d;
`endif
      end
   end

   // Next-state and datapath updates
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      valid_d = valid_q;
      cnt_d   = cnt_q;
`ifdef FETCH_TIMEOUT_EN
      wcnt_d  = wcnt_q;
      err_d   = err_q;
`endif
      case (state_q)
         REQ: begin
            if (mem_gnt) begin
               state_d = WAIT;
`ifdef FETCH_TIMEOUT_EN
               wcnt_d  = '0;
`endif
            end
         end
         WAIT: begin
            if (mem_rvalid) begin
               instr_d = mem_rdata;
               valid_d = 1'b1;
               state_d = HOLD;
            end
`ifdef FETCH_TIMEOUT_EN
            // Give up on a lost read and re-request the same pc.
            else if ((wcnt_q + WCNT_W'(1)) == WCNT_W'(TIMEOUT)) begin
               err_d   = 1'b1;
               state_d = REQ;
            end else begin
               wcnt_d  = wcnt_q + WCNT_W'(1);
            end
`endif
         end
         HOLD: begin
            if (instr_done) begin
               pc_d    = next_pc;
               valid_d = 1'b0;
               cnt_d   = cnt_q + RETIRE_W'(1);
               state_d = REQ;
            end
         end
         default: state_d = REQ;
      endcase
   end

   // Request is gated by reset so it stays low while reset is held.
   assign mem_req      = (state_q == REQ) && reset_n;
   assign mem_addr     = pc_q;
   assign pc           = pc_q;
   assign instr        = instr_q;
   assign instr_valid  = valid_q;
   assign retire_count = cnt_q;
`ifdef FETCH_TIMEOUT_EN
   assign fetch_err    = err_q;
`else
   assign fetch_err    = 1'b0;
`endif

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Sits on the far side of the next-PC interface from the branch resolver. Owns the architectural program counter and fetches the instruction at that PC from instruction memory over a request/grant/return handshake.
- Holds the instruction stable for the core. On retire it loads the resolver-supplied next PC and starts the next fetch.
- Its `pc`/`instr` outputs feed the branch resolver's address/instruction inputs; the resolver's result returns on `next_pc`.

Parameters:
- ADDR_W, 8, PC and memory address width
- INSTR_W, 16, instruction width
- RESET_PC, 0, PC value after reset
- TIMEOUT, 16, max cycles waiting for read data (optional feature only)

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- next_pc  input  ADDR_W  next PC from branch resolver, sampled on retire
- instr_done  input  1  core retires current instruction (meaningful only in HOLD)
- mem_req  output  1  read request to instruction memory
- mem_addr  output  ADDR_W  read address, equals pc while mem_req=1
- mem_gnt  input  1  memory accepts request this cycle
- mem_rvalid  input  1  read data valid
- mem_rdata  input  INSTR_W  read data
- pc  output  ADDR_W  current PC
- instr  output  INSTR_W  fetched instruction register
- instr_valid  output  1  instr holds the instruction at pc
- retire_count  output  16  count of retired instructions, wraps at 0xFFFF->0
- fetch_err  output  1  timeout flag (0 when feature compiled out)

Behaviour:
- Reset, async assert, sync release: state=REQ, pc=RESET_PC, instr=0, instr_valid=0, mem_req=0, retire_count=0, fetch_err=0.
- mem_req is combinational from state: 1 in REQ only. mem_addr=pc at all times.
- FSM states: REQ, WAIT, HOLD.
  - REQ: mem_req=1. On mem_gnt -> WAIT. Otherwise stay; mem_addr is held stable.
  - WAIT: on mem_rvalid, instr<=mem_rdata, instr_valid<=1, -> HOLD. Otherwise stay.
  - HOLD: instr_valid=1; instr and pc are stable. On instr_done: pc<=next_pc, instr_valid<=0, retire_count<=retire_count+1, -> REQ.
- mem_rvalid is ignored outside WAIT. It is never accepted in the same cycle as mem_gnt; earliest return is the cycle after the grant.
- instr_done is ignored outside HOLD: no PC change, no count increment.
- next_pc is taken verbatim. No increment or wrap logic here; wrap 0xFF->0x00 is the resolver's job.
- Minimum fetch latency, grant to instr_valid: 2 cycles. Back-to-back retire throughput is one instruction per 3 cycles with zero-wait memory.
- Reset mid-WAIT: any later stale mem_rvalid arrives in REQ and is ignored. The fetch restarts at RESET_PC.
- mem_gnt held high continuously: a new request is granted only when the FSM is in REQ.

Optional Feature:
- FETCH_TIMEOUT_EN defined:
  - An 8-bit wait counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT without mem_rvalid: fetch_err<=1 (sticky until reset), FSM -> REQ, re-request the same pc.
- FETCH_TIMEOUT_EN undefined: no counter, fetch_err tied 0, WAIT waits indefinitely.

Decomposition:
- Shared package `bitty_pkg`: ADDR_W/INSTR_W defaults, RESET_PC, and a fetch-state enum (REQ=2'd0, WAIT=2'd1, HOLD=2'd2). State encoding is visible to debug.
- No sub-module needed; the timeout counter stays inline under the macro.

Test Plan:
- Reset with reset_n low 3 cycles -> pc=0x00, instr_valid=0, mem_req=0 during reset; mem_req=1, mem_addr=0x00 on the first cycle after release.
- Zero-wait memory returns 0x1234 at addr 0, instr_done with next_pc=0x01 -> instr=0x1234 in HOLD, then pc=0x01, mem_addr=0x01, retire_count=1.
- Branch: HOLD at pc=0x05, next_pc=0x20 with instr_done -> next mem_addr=0x20, pc=0x20.
- Stall: mem_gnt low 4 cycles then high, rvalid 3 cycles later -> mem_req high all 5 REQ cycles, instr_valid only after rvalid.
- Spurious signals: instr_done pulsed in REQ/WAIT and mem_rvalid pulsed in REQ/HOLD -> pc, instr and retire_count unchanged.
- Timeout (FETCH_TIMEOUT_EN, TIMEOUT=4): grant at pc=0x03, no rvalid -> fetch_err=1 after 4 WAIT cycles, mem_req reasserts with mem_addr=0x03. Reset asserted mid-WAIT -> pc=0x00 and fetch_err=0.
